// File: rtl/edabk_receiver_controller.sv
// Oversampling serial receiver: start/data/optional even parity/stop framing on bclk.
// Optional parity checking is built only when EDABK_RX_PARITY_EN is defined.
`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_receiver_controller #(
  parameter int CLK_DIV    = `CFG_CLK_DIV,
  parameter int DATA_WIDTH = `CFG_DATA_WIDTH
) (
  input  logic                  bclk,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic                  parity,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  busy
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef EDABK_RX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta, rx_s;
  logic [TW-1:0]           tick_q, tick_d;
  logic [BW-1:0]           bits_q, bits_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;

`ifdef EDABK_RX_PARITY_EN
  logic                    par_flag_q, par_flag_d;
  logic                    perr_q, perr_d;
  logic                    perr_out_q, perr_out_d;
`else
  logic                    unused_parity;
  assign unused_parity = parity;
`endif

  // rx is asynchronous to bclk; only rx_s is ever looked at
  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bits_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef EDABK_RX_PARITY_EN
      par_flag_q <= 1'b0;
      perr_q     <= 1'b0;
      perr_out_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bits_q     <= bits_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef EDABK_RX_PARITY_EN
      par_flag_q <= par_flag_d;
      perr_q     <= perr_d;
      perr_out_q <= perr_out_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bits_d     = bits_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef EDABK_RX_PARITY_EN
    par_flag_d = par_flag_q;
    perr_d     = perr_q;
    perr_out_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          tick_d     = '0;
`ifdef EDABK_RX_PARITY_EN
          par_flag_d = parity;
          perr_d     = 1'b0;
`endif
        end
      end
      // Mid-start-bit check rejects short low glitches
      START: begin
        if (tick_q == TICK_HALF) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            tick_d  = '0;
            bits_d  = '0;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          if (bits_q == BITS_LAST) begin
`ifdef EDABK_RX_PARITY_EN
            state_d = par_flag_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bits_d = bits_q + BW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`ifdef EDABK_RX_PARITY_EN
      PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          perr_d  = (^shift_q) ^ rx_s;
          state_d = STOP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`endif
      STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rx_s) begin
            data_d     = shift_q;
            valid_d    = 1'b1;
`ifdef EDABK_RX_PARITY_EN
            perr_out_d = perr_q;
`endif
            state_d    = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      // A broken line must return high before a new start can be seen
      RECOVER: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out    = data_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != IDLE);
`ifdef EDABK_RX_PARITY_EN
  assign parity_error = perr_out_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_edabk_receiver_controller.sv
// Self-checking bench for edabk_receiver_controller: directed scenarios plus
// randomized frames scored against a frame-level reference model.
`timescale 1ns/1ps

module tb_edabk_receiver_controller;
  localparam int CLK_DIV = 16;
  localparam int DW      = 8;
`ifdef EDABK_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          bclk = 1'b0;
  logic          reset_n = 1'b1;
  logic          rx = 1'b1;
  logic          parity = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid, parity_error, frame_error, busy;

  int n_pass  = 0;
  int n_total = 0;

  // Observations gathered while a frame is driven
  int            o_vcnt, o_fcnt, o_pcnt, o_vedge, o_fedge, o_overlap, o_busy_low_tail;
  logic [DW-1:0] o_vdata;
  logic [DW-1:0] last_good;

  edabk_receiver_controller #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW)) dut (
    .bclk(bclk), .reset_n(reset_n), .rx(rx), .parity(parity),
    .data_out(data_out), .valid(valid), .parity_error(parity_error),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 bclk = ~bclk;

  // Edge (counted from the cycle rx first goes low) at which the stop-bit
  // result becomes visible: 2 synchronizer flops + the IDLE detection edge,
  // then half a bit plus the remaining whole bits.
  function automatic int exp_edge(input bit p);
    return 3 + CLK_DIV / 2 + (DW + (p ? 1 : 0) + 1) * CLK_DIV;
  endfunction

  // Drives one frame bit-by-bit; starts and ends at #1 after a rising edge.
  task automatic run_frame(input logic [DW-1:0] d, input bit with_par, input bit par_bit,
                           input bit stop_bit, input int tail, input bit tail_lvl,
                           input int limit);
    logic [DW+2:0] fb;
    int nb, total, bi;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < DW; i++) fb[i+1] = d[i];
    nb = DW + 2 + (with_par ? 1 : 0);
    if (with_par) fb[DW+1] = par_bit;
    fb[nb-1] = stop_bit;
    total = nb * CLK_DIV + tail;
    if (limit > 0 && limit < total) total = limit;
    o_vcnt = 0; o_fcnt = 0; o_pcnt = 0; o_vedge = -1; o_fedge = -1;
    o_overlap = 0; o_busy_low_tail = 0; o_vdata = '0;
    parity = with_par;
    rx = 1'b0;
    for (int n = 1; n <= total; n++) begin
      @(posedge bclk); #1;
      if (valid) begin
        o_vcnt++;
        if (o_vedge < 0) begin o_vedge = n; o_vdata = data_out; end
      end
      if (frame_error) begin
        o_fcnt++;
        if (o_fedge < 0) o_fedge = n;
      end
      if (parity_error) o_pcnt++;
      if (valid && frame_error) o_overlap++;
      if (parity_error && !valid) o_overlap++;
      if (n > nb * CLK_DIV && !tail_lvl && !busy) o_busy_low_tail++;
      bi = n / CLK_DIV;
      rx = (bi < nb) ? fb[bi] : tail_lvl;
      if (n == CLK_DIV / 2) parity = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    rx = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    n_total++; if (data_out !== '0) $display("FAIL reset_data got=%h exp=00", data_out); else n_pass++;
    n_total++; if ({valid, parity_error, frame_error} !== 3'b000)
      $display("FAIL reset_pulses got=%b exp=000", {valid, parity_error, frame_error}); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    repeat (3) @(posedge bclk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge bclk);
    #1;
    n_total++; if (busy !== 1'b0 || valid !== 1'b0)
      $display("FAIL reset_release got busy=%b valid=%b exp=0", busy, valid); else n_pass++;
    last_good = '0;
  endtask

  task automatic test_basic();
    run_frame(8'hA5, 1'b0, 1'b0, 1'b1, 2 * CLK_DIV, 1'b1, 0);
    n_total++; if (o_vcnt !== 1) $display("FAIL basic_vcnt got=%0d exp=1", o_vcnt); else n_pass++;
    n_total++; if (o_vedge !== exp_edge(1'b0))
      $display("FAIL basic_latency got=%0d exp=%0d", o_vedge, exp_edge(1'b0)); else n_pass++;
    n_total++; if (o_vdata !== 8'hA5) $display("FAIL basic_data got=%h exp=a5", o_vdata); else n_pass++;
    n_total++; if (o_pcnt !== 0 || o_fcnt !== 0)
      $display("FAIL basic_errors got p=%0d f=%0d exp=0", o_pcnt, o_fcnt); else n_pass++;
    n_total++; if (data_out !== 8'hA5) $display("FAIL basic_hold got=%h exp=a5", data_out); else n_pass++;
    last_good = 8'hA5;
  endtask

`ifdef EDABK_RX_PARITY_EN
  task automatic test_parity();
    run_frame(8'h3C, 1'b1, 1'b0, 1'b1, 2 * CLK_DIV, 1'b1, 0);
    n_total++; if (o_vcnt !== 1 || o_pcnt !== 0)
      $display("FAIL parity_good got v=%0d p=%0d exp v=1 p=0", o_vcnt, o_pcnt); else n_pass++;
    n_total++; if (o_vedge !== exp_edge(1'b1))
      $display("FAIL parity_latency got=%0d exp=%0d", o_vedge, exp_edge(1'b1)); else n_pass++;
    run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 2 * CLK_DIV, 1'b1, 0);
    n_total++; if (o_vcnt !== 1 || o_pcnt !== 1)
      $display("FAIL parity_bad got v=%0d p=%0d exp v=1 p=1", o_vcnt, o_pcnt); else n_pass++;
    n_total++; if (o_vdata !== 8'h3C) $display("FAIL parity_data got=%h exp=3c", o_vdata); else n_pass++;
    n_total++; if (o_overlap !== 0) $display("FAIL parity_align got=%0d exp=0", o_overlap); else n_pass++;
    last_good = 8'h3C;
  endtask
`else
  task automatic test_parity();
    run_frame(8'hA5, 1'b1, 1'b1, 1'b1, 2 * CLK_DIV, 1'b1, 0);
    n_total++; if (o_vcnt !== 1) $display("FAIL noparity_vcnt got=%0d exp=1", o_vcnt); else n_pass++;
    n_total++; if (o_vedge !== exp_edge(1'b0))
      $display("FAIL noparity_latency got=%0d exp=%0d", o_vedge, exp_edge(1'b0)); else n_pass++;
    n_total++; if (o_vdata !== 8'hA5) $display("FAIL noparity_data got=%h exp=a5", o_vdata); else n_pass++;
    n_total++; if (o_pcnt !== 0) $display("FAIL noparity_perr got=%0d exp=0", o_pcnt); else n_pass++;
    last_good = 8'hA5;
  endtask
`endif

  task automatic test_frame_error();
    int b2, b3;
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 40, 1'b0, 0);
    n_total++; if (o_fcnt !== 1) $display("FAIL ferr_cnt got=%0d exp=1", o_fcnt); else n_pass++;
    n_total++; if (o_fedge !== exp_edge(1'b0))
      $display("FAIL ferr_latency got=%0d exp=%0d", o_fedge, exp_edge(1'b0)); else n_pass++;
    n_total++; if (o_vcnt !== 0) $display("FAIL ferr_novalid got=%0d exp=0", o_vcnt); else n_pass++;
    n_total++; if (data_out !== last_good)
      $display("FAIL ferr_data_hold got=%h exp=%h", data_out, last_good); else n_pass++;
    n_total++; if (o_busy_low_tail !== 0)
      $display("FAIL ferr_busy_low got=%0d exp=0", o_busy_low_tail); else n_pass++;
    rx = 1'b1;
    b2 = -1; b3 = -1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge bclk); #1;
      if (n == 2) b2 = int'(busy);
      if (n == 3) b3 = int'(busy);
    end
    n_total++; if (b2 !== 1 || b3 !== 0)
      $display("FAIL ferr_recover got busy2=%0d busy3=%0d exp 1 0", b2, b3); else n_pass++;
    run_frame(8'h12, 1'b0, 1'b0, 1'b1, 2 * CLK_DIV, 1'b1, 0);
    n_total++; if (o_vcnt !== 1 || o_vdata !== 8'h12)
      $display("FAIL ferr_next got v=%0d d=%h exp v=1 d=12", o_vcnt, o_vdata); else n_pass++;
    last_good = 8'h12;
  endtask

  task automatic test_glitch();
    int pulses, b4, b40;
    pulses = 0; b4 = -1; b40 = -1;
    rx = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge bclk); #1;
      if (valid || frame_error || parity_error) pulses++;
      if (n == 4) begin b4 = int'(busy); rx = 1'b1; end
      if (n == 40) b40 = int'(busy);
    end
    n_total++; if (b4 !== 1) $display("FAIL glitch_start got busy=%0d exp=1", b4); else n_pass++;
    n_total++; if (b40 !== 0) $display("FAIL glitch_idle got busy=%0d exp=0", b40); else n_pass++;
    n_total++; if (pulses !== 0) $display("FAIL glitch_pulses got=%0d exp=0", pulses); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_frame(8'h01, 1'b0, 1'b0, 1'b1, 0, 1'b1, 0);
    n_total++; if (o_vcnt !== 1 || o_vdata !== 8'h01)
      $display("FAIL b2b_first got v=%0d d=%h exp v=1 d=01", o_vcnt, o_vdata); else n_pass++;
    run_frame(8'hFE, 1'b0, 1'b0, 1'b1, 2 * CLK_DIV, 1'b1, 0);
    n_total++; if (o_vcnt !== 1 || o_vdata !== 8'hFE)
      $display("FAIL b2b_second got v=%0d d=%h exp v=1 d=fe", o_vcnt, o_vdata); else n_pass++;
    n_total++; if (o_vedge !== exp_edge(1'b0))
      $display("FAIL b2b_latency got=%0d exp=%0d", o_vedge, exp_edge(1'b0)); else n_pass++;
    last_good = 8'hFE;
  endtask

  task automatic test_reset_midframe();
    int pulses;
    pulses = 0;
    run_frame(8'hFF, 1'b0, 1'b0, 1'b1, 0, 1'b1, 5 * CLK_DIV + CLK_DIV / 2);
    n_total++; if (busy !== 1'b1 || o_vcnt !== 0)
      $display("FAIL midreset_inframe got busy=%b v=%0d exp busy=1 v=0", busy, o_vcnt); else n_pass++;
    reset_n = 1'b0;
    rx = 1'b1;
    #1;
    n_total++; if ({data_out, valid, parity_error, frame_error, busy} !== '0)
      $display("FAIL midreset_outputs got d=%h v=%b p=%b f=%b b=%b exp all 0",
               data_out, valid, parity_error, frame_error, busy); else n_pass++;
    repeat (2) @(posedge bclk);
    #1 reset_n = 1'b1;
    for (int n = 0; n < 3 * CLK_DIV; n++) begin
      @(posedge bclk); #1;
      if (valid || frame_error || busy) pulses++;
    end
    n_total++; if (pulses !== 0) $display("FAIL midreset_quiet got=%0d exp=0", pulses); else n_pass++;
    run_frame(8'h81, 1'b0, 1'b0, 1'b1, 2 * CLK_DIV, 1'b1, 0);
    n_total++; if (o_vcnt !== 1 || o_vdata !== 8'h81 || o_vedge !== exp_edge(1'b0))
      $display("FAIL midreset_next got v=%0d d=%h e=%0d exp v=1 d=81 e=%0d",
               o_vcnt, o_vdata, o_vedge, exp_edge(1'b0)); else n_pass++;
    last_good = 8'h81;
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    bit wp, pb, sb, p_eff, stop_eff, exp_perr;
    int e_v, e_f, e_p, e_edge;
    for (int k = 0; k < 20; k++) begin
      d  = DW'($urandom);
      wp = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      sb = ((PAR_EN || !wp) && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      // Without the parity build a parity bit on the wire is taken as the stop bit
      p_eff    = PAR_EN && wp;
      stop_eff = (PAR_EN || !wp) ? sb : pb;
      exp_perr = p_eff && (((^d) ^ pb) == 1'b1);
      e_v    = stop_eff ? 1 : 0;
      e_f    = stop_eff ? 0 : 1;
      e_p    = (stop_eff && exp_perr) ? 1 : 0;
      e_edge = exp_edge(p_eff);
      run_frame(d, wp, pb, sb, 2 * CLK_DIV, 1'b1, 0);
      if (stop_eff) last_good = d;
      n_total++; if (o_vcnt !== e_v || o_fcnt !== e_f || o_pcnt !== e_p)
        $display("FAIL rand%0d_pulses got v=%0d f=%0d p=%0d exp v=%0d f=%0d p=%0d",
                 k, o_vcnt, o_fcnt, o_pcnt, e_v, e_f, e_p); else n_pass++;
      n_total++; if ((stop_eff ? o_vedge : o_fedge) !== e_edge)
        $display("FAIL rand%0d_latency got=%0d exp=%0d", k, stop_eff ? o_vedge : o_fedge, e_edge);
      else n_pass++;
      n_total++; if (data_out !== last_good)
        $display("FAIL rand%0d_data got=%h exp=%h", k, data_out, last_good); else n_pass++;
      n_total++; if (o_overlap !== 0) $display("FAIL rand%0d_align got=%0d exp=0", k, o_overlap);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
